prc_lcd_copy: RTL and testbench



---
 rtl/prc_pkg.sv | 42 ++++
 rtl/prc_lcd_copy_if.sv | 23 ++
 rtl/prc_lcd_copy.sv | 160 ++++++++++++++++
 tb/tb_prc_lcd_copy.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prc_pkg.sv
// Shared types and constants for the PRC framebuffer-to-LCD copy sequencer.
package prc_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_REQ      = 4'd1;
  localparam logic [3:0] ST_CMD_WR   = 4'd2;
  localparam logic [3:0] ST_CMD_GAP  = 4'd3;
  localparam logic [3:0] ST_RD       = 4'd4;
  localparam logic [3:0] ST_CAP      = 4'd5;
  localparam logic [3:0] ST_DAT_WR   = 4'd6;
  localparam logic [3:0] ST_DAT_GAP  = 4'd7;
  localparam logic [3:0] ST_RELEASE  = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    REQ      = ST_REQ,
    CMD_WR   = ST_CMD_WR,
    CMD_GAP  = ST_CMD_GAP,
    RD       = ST_RD,
    CAP      = ST_CAP,
    DAT_WR   = ST_DAT_WR,
    DAT_GAP  = ST_DAT_GAP,
    RELEASE  = ST_RELEASE
  } prc_copy_state_t;

  localparam logic [23:0] LCD_CMD_ADDR  = 24'h20FE;
  localparam logic [23:0] LCD_DATA_ADDR = 24'h20FF;

  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;

  // Command byte for position idx of the three-command page preamble.
  function automatic logic [7:0] lcd_cmd(input logic [1:0] idx, input logic [7:0] page);
    case (idx)
      2'd0:    lcd_cmd = CMD_PAGE | page;
      2'd1:    lcd_cmd = CMD_COL_LO;
      default: lcd_cmd = CMD_COL_HI;
    endcase
  endfunction

endpackage

// File: rtl/prc_lcd_copy_if.sv
// System-bus port of the copy sequencer (master = sequencer, slave = bus/RAM side).
interface prc_lcd_copy_if;
  // bus_request is held until the copy ends; bus_ack grants ownership and must stay
  // high throughout. Strobes (bus_write/bus_read) are single-ce pulses qualified by
  // address_out/data_out; data_in is valid on the ce cycle following bus_read.
  logic        bus_request;
  logic        bus_ack;
  logic [23:0] address_out;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        bus_write;
  logic        bus_read;

  modport master (
    output bus_request, address_out, data_out, bus_write, bus_read,
    input  bus_ack, data_in
  );

  modport slave (
    input  bus_request, address_out, data_out, bus_write, bus_read,
    output bus_ack, data_in
  );
endinterface

// File: rtl/prc_lcd_copy.sv
// Copies the 96x64 framebuffer from work RAM into the LCD controller, one frame per start.
// Optional PRC_COPY_BLANK_EN adds a blank input that turns the frame into all-zero writes.
module prc_lcd_copy
  import prc_pkg::*;
#(
  parameter logic [23:0] FB_BASE = 24'h001000,
  parameter int          COLUMNS = 96,
  parameter int          PAGES   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_ce,
    input  logic             start,
`ifdef PRC_COPY_BLANK_EN
    input  logic             blank,
`endif
    prc_lcd_copy_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output prc_copy_state_t  dbg_state_o
);

    localparam int COL_W  = $clog2(COLUMNS);
    localparam int PAGE_W = $clog2(PAGES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    prc_copy_state_t   state_q, state_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        cmd_idx_q, cmd_idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              blank_q, blank_d;
    logic              aborted_q, aborted_d;
    logic              blank_in;
    logic              copy_active;
    logic [9:0]        fb_off;

`ifdef PRC_COPY_BLANK_EN
    assign blank_in = blank;
`else
    assign blank_in = 1'b0;
`endif

    assign copy_active = (state_q == CMD_WR) || (state_q == CMD_GAP) ||
                         (state_q == RD)     || (state_q == CAP)     ||
                         (state_q == DAT_WR) || (state_q == DAT_GAP);

    assign fb_off = 10'(page_q) * 10'(COLUMNS) + 10'(col_q);

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        col_d     = col_q;
        cmd_idx_d = cmd_idx_q;
        byte_d    = byte_q;
        blank_d   = blank_q;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = REQ;
                    page_d    = '0;
                    col_d     = '0;
                    cmd_idx_d = '0;
                    blank_d   = blank_in;
                end
            end
            REQ:     if (bus.bus_ack) state_d = CMD_WR;
            CMD_WR:  state_d = CMD_GAP;
            CMD_GAP: begin
                if (cmd_idx_q == 2'd2) begin
                    state_d = blank_q ? DAT_WR : RD;
                end else begin
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    state_d   = CMD_WR;
                end
            end
            RD:      state_d = CAP;
            CAP: begin
                byte_d  = bus.data_in;
                state_d = DAT_WR;
            end
            DAT_WR:  state_d = DAT_GAP;
            DAT_GAP: begin
                if (col_q != COL_LAST) begin
                    col_d   = col_q + COL_W'(1);
                    state_d = blank_q ? DAT_WR : RD;
                end else if (page_q != PAGE_LAST) begin
                    page_d    = page_q + PAGE_W'(1);
                    col_d     = '0;
                    cmd_idx_d = '0;
                    state_d   = CMD_WR;
                end else begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Losing the grant mid-copy overrides everything, including a pending start.
        if (copy_active && !bus.bus_ack) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            page_q    <= '0;
            col_q     <= '0;
            cmd_idx_q <= '0;
            byte_q    <= '0;
            blank_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else if (clk_ce) begin
            state_q   <= state_d;
            page_q    <= page_d;
            col_q     <= col_d;
            cmd_idx_q <= cmd_idx_d;
            byte_q    <= byte_d;
            blank_q   <= blank_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs decode straight from registered state, so async reset clears them at once.
    always_comb begin
        bus.bus_request = (state_q == REQ) || copy_active;
        bus.bus_write   = 1'b0;
        bus.bus_read    = 1'b0;
        bus.address_out = '0;
        bus.data_out    = '0;
        unique case (state_q)
            CMD_WR: begin
                bus.address_out = LCD_CMD_ADDR;
                bus.data_out    = lcd_cmd(cmd_idx_q, 8'(page_q));
                bus.bus_write   = 1'b1;
            end
            RD: begin
                bus.address_out = FB_BASE + {14'd0, fb_off};
                bus.bus_read    = 1'b1;
            end
            DAT_WR: begin
                bus.address_out = LCD_DATA_ADDR;
                bus.data_out    = blank_q ? 8'h00 : byte_q;
                bus.bus_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == RELEASE);
    assign aborted     = aborted_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prc_lcd_copy.sv
// Bench for prc_lcd_copy: RAM/LCD models, expected-write scoreboard, timing and abort checks.
// Exercises the blank-frame path when PRC_COPY_BLANK_EN is defined.
module tb_prc_lcd_copy;
  import prc_pkg::*;

  localparam logic [23:0] FB_BASE = 24'h001000;
  localparam int COLS   = 96;
  localparam int PAGES  = 8;
  localparam int NBYTES = COLS * PAGES;

  logic clk = 1'b0;
  logic reset_n, clk_ce, start, busy, done, aborted;
`ifdef PRC_COPY_BLANK_EN
  logic blank;
`endif
  prc_copy_state_t dbg_state;

  prc_lcd_copy_if bus ();

  prc_lcd_copy #(.FB_BASE(FB_BASE), .COLUMNS(COLS), .PAGES(PAGES)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_ce      (clk_ce),
    .start       (start),
`ifdef PRC_COPY_BLANK_EN
    .blank       (blank),
`endif
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0]  ram [NBYTES];
  logic [31:0] exp_q [$];
  int n_vec, n_err;
  int ce_mode, ce_cnt;
  int wr_cnt, rd_cnt, done_cnt, abort_cnt, frame_ce, exp_done_ce;
  int base_wr, base_rd, base_done;
  logic prev_wr, prev_rd, snap_ok;
  logic [39:0] snap;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] out_vec();
    return {2'b00, bus.address_out, bus.data_out, bus.bus_write, bus.bus_read,
            bus.bus_request, busy, done, aborted};
  endfunction

  // Reference frame: per page three commands then the page's bytes in column order.
  task automatic build_exp(input bit blk);
    logic [7:0] cmd;
    exp_q.delete();
    for (int p = 0; p < PAGES; p++) begin
      for (int k = 0; k < 3; k++) begin
        cmd = (k == 0) ? (8'hB0 + 8'(p)) : ((k == 1) ? 8'h00 : 8'h10);
        exp_q.push_back({24'h0020FE, cmd});
      end
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({24'h0020FF, blk ? 8'h00 : ram[p * COLS + c]});
    end
  endtask

  // One clock: observe at the falling edge, act as RAM + LCD, choose next clk_ce.
  task automatic step();
    logic old_ce;
    int idx;
    @(negedge clk);
    old_ce = clk_ce;
    if (!reset_n) begin
      snap_ok  = 1'b0;
      frame_ce = -1;
      prev_wr  = 1'b0;
      prev_rd  = 1'b0;
    end else begin
      if (snap_ok && !old_ce) chk("hold", out_vec(), snap);
      snap    = out_vec();
      snap_ok = 1'b1;
    end
    case (ce_mode)
      0: clk_ce = 1'b1;
      1: begin ce_cnt = (ce_cnt + 1) % 4; clk_ce = (ce_cnt == 0); end
      default: clk_ce = 1'($urandom_range(0, 1));
    endcase
    if (reset_n && clk_ce) begin
      if (frame_ce >= 0) frame_ce++;
      else if (bus.bus_write) frame_ce = 0;
      if (bus.bus_write) begin
        chk("pace_wr", {39'd0, prev_wr}, 40'd0);
        if (exp_q.size() == 0) chk("extra_wr", 40'd1, 40'd0);
        else chk("lcd_wr", {8'd0, bus.address_out, bus.data_out}, {8'd0, exp_q.pop_front()});
        wr_cnt++;
      end
      if (bus.bus_read) begin
        chk("pace_rd", {39'd0, prev_rd}, 40'd0);
        idx = int'(bus.address_out) - int'(FB_BASE);
        if (idx < 0 || idx >= NBYTES) begin
          chk("rd_range", 40'd1, 40'd0);
          bus.data_in = 8'hEE;
        end else begin
          bus.data_in = ram[idx];
        end
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("done_ce", 40'(frame_ce), 40'(exp_done_ce));
        frame_ce = -1;
      end
      if (aborted) begin
        abort_cnt++;
        frame_ce = -1;
      end
      prev_wr = bus.bus_write;
      prev_rd = bus.bus_read;
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    int n;
    n = 0;
    while (!clk_ce && n < 16) begin step(); n++; end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic begin_frame(input bit blk);
    base_wr     = wr_cnt;
    base_rd     = rd_cnt;
    base_done   = done_cnt;
    exp_done_ce = blk ? 1584 : 3120;
    build_exp(blk);
    pulse_start();
  endtask

  task automatic end_frame(input string tag, input int exp_rd, input int budget);
    int n, d0, a0;
    n  = 0;
    d0 = done_cnt;
    a0 = abort_cnt;
    while (done_cnt == d0 && abort_cnt == a0 && n < budget) begin step(); n++; end
    if (n >= budget) chk({tag, "_timeout"}, 40'd0, 40'd1);
    repeat (8) step();
    chk({tag, "_nwr"},   40'(wr_cnt - base_wr), 40'd792);
    chk({tag, "_nrd"},   40'(rd_cnt - base_rd), 40'(exp_rd));
    chk({tag, "_ndone"}, 40'(done_cnt - base_done), 40'd1);
    chk({tag, "_left"},  40'(exp_q.size()), 40'd0);
    chk({tag, "_idle"},  {39'd0, busy}, 40'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NBYTES; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int n, a0, d0, w0;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; start = 1'b0; clk_ce = 1'b1;
    bus.bus_ack = 1'b0; bus.data_in = 8'h00;
`ifdef PRC_COPY_BLANK_EN
    blank = 1'b0;
`endif
    ce_mode = 0; ce_cnt = 0;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; abort_cnt = 0;
    frame_ce = -1; exp_done_ce = 3120;
    prev_wr = 1'b0; prev_rd = 1'b0; snap_ok = 1'b0; snap = '0;
    for (int i = 0; i < NBYTES; i++) ram[i] = 8'((int'(FB_BASE) + i) & 8'hFF);

    #23;
    chk("rst_outs", out_vec(), 40'd0);
    chk("rst_state", {36'd0, dbg_state}, {36'd0, IDLE});
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("idle_busy", {39'd0, busy}, 40'd0);
    bus.bus_ack = 1'b1;

    // full copy, every cycle a ce
    begin_frame(1'b0);
    end_frame("full", 768, 4000);

    // 1-in-4 clock enable, then random enable
    ce_mode = 1;
    fill_random();
    begin_frame(1'b0);
    end_frame("ce4", 768, 14000);
    ce_mode = 2;
    fill_random();
    begin_frame(1'b0);
    end_frame("ce_rand", 768, 9000);
    ce_mode = 0;

    // grant loss at page 3, column 40 data write (write index 3*99+3+40)
    fill_random();
    a0 = abort_cnt; d0 = done_cnt; w0 = wr_cnt;
    begin_frame(1'b0);
    n = 0;
    while (wr_cnt - w0 < 341 && n < 2000) begin step(); n++; end
    if (n >= 2000) chk("abort_point_timeout", 40'd0, 40'd1);
    chk("abort_point", {15'd0, bus.bus_write, bus.address_out}, {15'd0, 1'b1, 24'h0020FF});
    bus.bus_ack = 1'b0;
    step();
    chk("abort_pulse", {39'd0, aborted}, 40'd1);
    chk("abort_strobes", {38'd0, bus.bus_write, bus.bus_read}, 40'd0);
    chk("abort_req", {39'd0, bus.bus_request}, 40'd0);
    chk("abort_busy", {39'd0, busy}, 40'd0);
    repeat (4) step();
    chk("abort_once", 40'(abort_cnt - a0), 40'd1);
    chk("abort_no_done", 40'(done_cnt - d0), 40'd0);
    chk("abort_clear", {39'd0, aborted}, 40'd0);
    bus.bus_ack = 1'b1;
    begin_frame(1'b0);
    end_frame("restart", 768, 4000);

    // start while busy is ignored
    fill_random();
    begin_frame(1'b0);
    n = 0;
    while (frame_ce != 1000 && n < 2000) begin step(); n++; end
    if (n >= 2000) chk("busy_start_timeout", 40'd0, 40'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    end_frame("busy_start", 768, 4000);
    repeat (500) step();
    chk("busy_start_nwr", 40'(wr_cnt - base_wr), 40'd792);
    chk("busy_start_ndone", 40'(done_cnt - base_done), 40'd1);
    chk("busy_start_idle", {39'd0, busy}, 40'd0);

    // asynchronous reset during a read
    begin_frame(1'b0);
    n = 0;
    while (!bus.bus_read && n < 100) begin step(); n++; end
    if (n >= 100) chk("arst_timeout", 40'd0, 40'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outs", out_vec(), 40'd0);
    chk("arst_state", {36'd0, dbg_state}, {36'd0, IDLE});
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("arst_busy", {39'd0, busy}, 40'd0);
    chk("arst_state2", {36'd0, dbg_state}, {36'd0, IDLE});
    repeat (5) step();
    chk("arst_idle", {39'd0, busy}, 40'd0);

`ifdef PRC_COPY_BLANK_EN
    // blank frame: no reads, zero data, shorter frame
    fill_random();
    blank = 1'b1;
    begin_frame(1'b1);
    blank = 1'b0;
    end_frame("blank", 0, 2500);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
